reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer for the Tomasulo core.
- Issues rename tags to ID and captures results from the CDB.
- Retires entries in program order through a registered commit port into the register file, which updates regs and clears busy when tags match.
- Tag 0 is reserved to mean "no producer", so it is never issued.

Parameters:
TAG_W, 4, tag width; DEPTH = 2^TAG_W - 1 entries; valid tags 1..DEPTH
DATA_W, 32, result data width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
rdy  input  1  global ready; low freezes all state
alloc_valid  input  1  ID requests a new entry
alloc_dest_valid  input  1  instruction writes a register
alloc_dest_addr  input  5  destination register
alloc_tag  output  TAG_W  tag assigned to the current request (= tail), combinational
full  output  1  no free entry (count == DEPTH), combinational
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_W  producing entry
cdb_data  input  DATA_W  result
flush  input  1  discard all entries (mispredict)
commit_valid  output  1  one entry retired this cycle (registered)
commit_we  output  1  retired entry writes a register (registered)
commit_addr  output  5  register to write (registered)
commit_data  output  DATA_W  value to write (registered)
commit_tag  output  TAG_W  tag of the retired entry (registered)
count  output  TAG_W  occupied entries

Behaviour:
- Reset (asynchronous, rst=1):
  - head = tail = 1, count = 0.
  - All entry busy/ready bits = 0.
  - commit_valid, commit_we, commit_addr, commit_data, commit_tag = 0.
  - full = 0, alloc_tag = 1.
- Entry fields: busy, ready, dest_valid, dest_addr, data.
- rdy=0: no state change; registered outputs hold.
- Allocation:
  - Accepted at a posedge when alloc_valid & !full & rdy.
  - Entry[tail] gets busy=1, ready=0, and the dest fields from ID.
  - tail advances: tail==DEPTH wraps to 1.
  - full is evaluated from count before the edge: a full buffer rejects allocation even if a commit frees an entry on the same edge.
- CDB capture:
  - When cdb_valid and entry[cdb_tag] is busy, set data=cdb_data and ready=1.
  - cdb_tag==0 or a non-busy target is ignored.
- Commit:
  - Triggers at a posedge when entry[head] is busy & ready.
  - Registers commit_valid=1, commit_tag=head, commit_addr, commit_data.
  - commit_we = dest_valid & (dest_addr != 0).
  - Clears entry[head].busy; head advances with the same 1..DEPTH wrap.
  - Otherwise commit_valid=0 and commit_we=0; addr/data/tag hold.
  - At most one retirement per cycle.
- Latency:
  - A CDB result captured at edge N is visible on the commit outputs at edge N+1 at the earliest (ready is registered).
  - Allocation to commit takes at least 2 edges.
- count:
  - Increments on accept only; decrements on commit only.
  - Unchanged when accept and commit happen together.
- Simultaneous events:
  - Allocate + commit + CDB in the same cycle are all legal.
  - A CDB write to the entry being committed cannot occur, because that entry is already ready.
- flush (with rdy=1) overrides everything on that edge:
  - All busy bits = 0, head = tail = 1, count = 0.
  - commit_valid = commit_we = 0.
  - The alloc request is dropped; CDB and commit are ignored.
- Reset asserted mid-operation discards all entries immediately, with no commit pulse.

Optional Feature:
- Macro: ROB_QUERY_EN.
- Enabled: adds two combinational query ports for dispatch.
  - Inputs: query1_tag, query2_tag.
  - Outputs: query1_ready, query1_data, query2_ready, query2_data.
  - ready = busy & ready for the queried entry.
  - A same-cycle CDB match on the queried tag also returns ready=1 with cdb_data (bypass).
  - Tag 0 returns ready=0 and data=0.
- Disabled: these ports and their logic do not exist.

Test Plan:
- Reset, then allocate 3 entries (dest x1, x2, x0) → alloc_tag 1, 2, 3; count=3. CDB tag1=0xA, tag2=0xB, tag3=0xC → commit pulses on successive cycles: (we=1, x1, 0xA), (we=1, x2, 0xB), (we=0 for x0), with tags 1, 2, 3.
- Out-of-order completion: CDB tag2 arrives before tag1 → no commit until tag1 is ready; then tag1 and tag2 commit on consecutive cycles.
- Fill 15 entries → full=1 and a 16th request is rejected. Complete tag1 → commit; full drops next cycle. The next allocation receives tag 1 (wrap from 15).
- Full buffer with alloc_valid and a ready head on the same edge → commit occurs, allocation is rejected, count 15→14.
- Flush with 5 busy entries, one ready → no commit pulse, count=0, next alloc_tag=1. Rst pulsed mid-stream → outputs return to 0 asynchronously.
- rdy=0 for 3 cycles with a ready head → no commit and state is frozen; commit occurs on the first edge after rdy returns to 1.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: issues rename tags, captures CDB results, retires in order.
// Optional dispatch query ports are compiled in with ROB_QUERY_EN.
module reorder_buffer #(
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              alloc_valid,
   input  logic              alloc_dest_valid,
   input  logic [4:0]        alloc_dest_addr,
   output logic [TAG_W-1:0]  alloc_tag,
   output logic              full,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              flush,
   output logic              commit_valid,
   output logic              commit_we,
   output logic [4:0]        commit_addr,
   output logic [DATA_W-1:0] commit_data,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [TAG_W-1:0]  count
`ifdef ROB_QUERY_EN
   ,
   input  logic [TAG_W-1:0]  query1_tag,
   input  logic [TAG_W-1:0]  query2_tag,
   output logic              query1_ready,
   output logic [DATA_W-1:0] query1_data,
   output logic              query2_ready,
   output logic [DATA_W-1:0] query2_data
`endif
);

   localparam int unsigned NUM_SLOTS = 2 ** TAG_W;
   // Slot 0 exists only so tags index directly; it is never allocated.
   localparam logic [TAG_W-1:0] DEPTH_TAG = {TAG_W{1'b1}};
   localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);

   logic [TAG_W-1:0]     head_q, head_d;
   logic [TAG_W-1:0]     tail_q, tail_d;
   logic [TAG_W-1:0]     count_q, count_d;
   logic [NUM_SLOTS-1:0] busy_q, busy_d;
   logic [NUM_SLOTS-1:0] ready_q, ready_d;

   logic                 dest_valid_q [NUM_SLOTS];
   logic [4:0]           dest_addr_q  [NUM_SLOTS];
   logic [DATA_W-1:0]    data_q       [NUM_SLOTS];

   logic                 commit_valid_q, commit_valid_d;
   logic                 commit_we_q, commit_we_d;
   logic [4:0]           commit_addr_q, commit_addr_d;
   logic [DATA_W-1:0]    commit_data_q, commit_data_d;
   logic [TAG_W-1:0]     commit_tag_q, commit_tag_d;

   logic                 alloc_fire;
   logic                 commit_fire;
   logic                 cdb_fire;

   function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] t);
      return (t == DEPTH_TAG) ? FIRST_TAG : t + FIRST_TAG;
   endfunction

   always_comb begin
      full        = (count_q == DEPTH_TAG);
      alloc_tag   = tail_q;
      count       = count_q;
      alloc_fire  = rdy & ~flush & alloc_valid & ~full;
      commit_fire = rdy & ~flush & busy_q[head_q] & ready_q[head_q];
      cdb_fire    = rdy & ~flush & cdb_valid & (cdb_tag != '0) & busy_q[cdb_tag];
   end

   // Next-state for the control arrays and pointers.
   always_comb begin
      busy_d  = busy_q;
      ready_d = ready_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (cdb_fire) begin
         ready_d[cdb_tag] = 1'b1;
      end
      if (commit_fire) begin
         busy_d[head_q] = 1'b0;
         head_d         = wrap_inc(head_q);
      end
      if (alloc_fire) begin
         busy_d[tail_q]  = 1'b1;
         ready_d[tail_q] = 1'b0;
         tail_d          = wrap_inc(tail_q);
      end

      unique case ({alloc_fire, commit_fire})
         2'b10:   count_d = count_q + FIRST_TAG;
         2'b01:   count_d = count_q - FIRST_TAG;
         default: count_d = count_q;
      endcase

      if (flush) begin
         busy_d  = '0;
         ready_d = '0;
         head_d  = FIRST_TAG;
         tail_d  = FIRST_TAG;
         count_d = '0;
      end
   end

   always_comb begin
      commit_valid_d = commit_fire;
      commit_we_d    = commit_fire & dest_valid_q[head_q] & (dest_addr_q[head_q] != 5'd0);
      commit_addr_d  = commit_addr_q;
      commit_data_d  = commit_data_q;
      commit_tag_d   = commit_tag_q;
      if (commit_fire) begin
         commit_addr_d = dest_addr_q[head_q];
         commit_data_d = data_q[head_q];
         commit_tag_d  = head_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q         <= FIRST_TAG;
         tail_q         <= FIRST_TAG;
         count_q        <= '0;
         busy_q         <= '0;
         ready_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_we_q    <= 1'b0;
         commit_addr_q  <= '0;
         commit_data_q  <= '0;
         commit_tag_q   <= '0;
      end else if (rdy) begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         busy_q         <= busy_d;
         ready_q        <= ready_d;
         commit_valid_q <= commit_valid_d;
         commit_we_q    <= commit_we_d;
         commit_addr_q  <= commit_addr_d;
         commit_data_q  <= commit_data_d;
         commit_tag_q   <= commit_tag_d;
      end
   end

   // Payload needs no reset: it is only read while the matching busy bit is set.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         dest_valid_q[tail_q] <= alloc_dest_valid;
         dest_addr_q[tail_q]  <= alloc_dest_addr;
      end
      if (cdb_fire) begin
         data_q[cdb_tag] <= cdb_data;
      end
   end

   assign commit_valid = commit_valid_q;
   assign commit_we    = commit_we_q;
   assign commit_addr  = commit_addr_q;
   assign commit_data  = commit_data_q;
   assign commit_tag   = commit_tag_q;

`ifdef ROB_QUERY_EN
   // A same-cycle CDB broadcast to a busy entry is bypassed straight to dispatch.
   always_comb begin
      query1_ready = 1'b0;
      query1_data  = '0;
      query2_ready = 1'b0;
      query2_data  = '0;
      if (query1_tag != '0 && busy_q[query1_tag]) begin
         if (cdb_valid && cdb_tag == query1_tag) begin
            query1_ready = 1'b1;
            query1_data  = cdb_data;
         end else if (ready_q[query1_tag]) begin
            query1_ready = 1'b1;
            query1_data  = data_q[query1_tag];
         end
      end
      if (query2_tag != '0 && busy_q[query2_tag]) begin
         if (cdb_valid && cdb_tag == query2_tag) begin
            query2_ready = 1'b1;
            query2_data  = cdb_data;
         end else if (ready_q[query2_tag]) begin
            query2_ready = 1'b1;
            query2_data  = data_q[query2_tag];
         end
      end
   end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed scenarios plus randomized traffic
// checked against a program-order queue model.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        alloc_valid = 1'b0;
   logic        alloc_dest_valid = 1'b0;
   logic [4:0]  alloc_dest_addr = '0;
   logic [3:0]  alloc_tag;
   logic        full;
   logic        cdb_valid = 1'b0;
   logic [3:0]  cdb_tag = '0;
   logic [31:0] cdb_data = '0;
   logic        flush = 1'b0;
   logic        commit_valid;
   logic        commit_we;
   logic [4:0]  commit_addr;
   logic [31:0] commit_data;
   logic [3:0]  commit_tag;
   logic [3:0]  count;

   reorder_buffer #(.TAG_W(4), .DATA_W(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .rdy              (rdy),
      .alloc_valid      (alloc_valid),
      .alloc_dest_valid (alloc_dest_valid),
      .alloc_dest_addr  (alloc_dest_addr),
      .alloc_tag        (alloc_tag),
      .full             (full),
      .cdb_valid        (cdb_valid),
      .cdb_tag          (cdb_tag),
      .cdb_data         (cdb_data),
      .flush            (flush),
      .commit_valid     (commit_valid),
      .commit_we        (commit_we),
      .commit_addr      (commit_addr),
      .commit_data      (commit_data),
      .commit_tag       (commit_tag),
      .count            (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  tag;
      bit          dv;
      logic [4:0]  addr;
      logic [31:0] data;
      bit          done;
   } ent_t;

   ent_t        rob_q[$];
   logic [41:0] exp_q[$];
   logic [3:0]  m_next_tag = 4'd1;
   bit          m_cv = 1'b0;
   bit          m_we = 1'b0;
   bit          live = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      rob_q.delete();
      exp_q.delete();
      m_next_tag = 4'd1;
      m_cv = 1'b0;
      m_we = 1'b0;
      live = 1'b0;
   endtask

   // One clock edge of the reference model, from the pre-edge model state.
   task automatic model_step(input bit a, input bit dv, input logic [4:0] ad, input bit cv,
                             input logic [3:0] ct, input logic [31:0] cd, input bit fl,
                             input bit r);
      bit was_full;
      bit do_commit;
      ent_t e;
      if (!r) return;
      if (fl) begin
         rob_q.delete();
         m_next_tag = 4'd1;
         m_cv = 1'b0;
         m_we = 1'b0;
         return;
      end
      was_full  = (rob_q.size() == 15);
      do_commit = (rob_q.size() > 0) && rob_q[0].done;
      if (do_commit) begin
         m_cv = 1'b1;
         m_we = rob_q[0].dv && (rob_q[0].addr != 5'd0);
         exp_q.push_back({rob_q[0].tag, m_we, rob_q[0].addr, rob_q[0].data});
      end else begin
         m_cv = 1'b0;
         m_we = 1'b0;
      end
      if (cv && ct != 4'd0) begin
         foreach (rob_q[j]) begin
            if (rob_q[j].tag == ct) begin
               rob_q[j].done = 1'b1;
               rob_q[j].data = cd;
            end
         end
      end
      if (do_commit) void'(rob_q.pop_front());
      if (a && !was_full) begin
         e.tag = m_next_tag; e.dv = dv; e.addr = ad; e.data = '0; e.done = 1'b0;
         rob_q.push_back(e);
         m_next_tag = (m_next_tag == 4'd15) ? 4'd1 : m_next_tag + 4'd1;
      end
   endtask

   task automatic cyc(input bit a, input bit dv, input logic [4:0] ad, input bit cv,
                      input logic [3:0] ct, input logic [31:0] cd, input bit fl = 1'b0,
                      input bit r = 1'b1);
      alloc_valid = a; alloc_dest_valid = dv; alloc_dest_addr = ad;
      cdb_valid = cv; cdb_tag = ct; cdb_data = cd; flush = fl; rdy = r;
      @(posedge clk);
      model_step(a, dv, ad, cv, ct, cd, fl, r);
      live = r;
      #2;
      alloc_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0; rdy = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0);
   endtask

   task automatic alloc(input bit dv, input logic [4:0] ad);
      cyc(1'b1, dv, ad, 1'b0, 4'd0, 32'd0);
   endtask

   task automatic cdb(input logic [3:0] ct, input logic [31:0] cd);
      cyc(1'b0, 1'b0, 5'd0, 1'b1, ct, cd);
   endtask

   // Monitor: pops the scoreboard whenever the model says a retirement happened.
   always @(negedge clk) begin
      if (!rst) begin
         chk("count", 64'(count), 64'(rob_q.size()));
         chk("full", 64'(full), 64'(rob_q.size() == 15));
         chk("alloc_tag", 64'(alloc_tag), 64'(m_next_tag));
         chk("commit_valid", 64'(commit_valid), 64'(m_cv));
         if (live && m_cv) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_empty", 64'(1), 64'(0));
            end else begin
               chk("commit", 64'({commit_tag, commit_we, commit_addr, commit_data}),
                   64'(exp_q.pop_front()));
            end
         end else begin
            chk("commit_we", 64'(commit_we), 64'(m_we));
         end
      end
   end

   bit          ra, rdv, rcv, rfl, rr;
   logic [4:0]  rad;
   logic [3:0]  rct;
   logic [31:0] rcd;
   int          pend[$];

   initial begin
      repeat (2) @(posedge clk);
      #2;
      chk("rst_commit_valid", 64'(commit_valid), 64'(0));
      chk("rst_commit_out", 64'({commit_we, commit_addr, commit_data, commit_tag}), 64'(0));
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_full", 64'(full), 64'(0));
      chk("rst_alloc_tag", 64'(alloc_tag), 64'(1));
      rst = 1'b0;
      model_reset();

      // In-order retire with an x0 destination.
      alloc(1'b1, 5'd1);
      alloc(1'b1, 5'd2);
      alloc(1'b1, 5'd0);
      chk("three_alloc_count", 64'(count), 64'(3));
      cdb(4'd1, 32'hA);
      cdb(4'd2, 32'hB);
      cdb(4'd3, 32'hC);
      idle(3);

      // Out-of-order completion (tags 4 and 5).
      alloc(1'b1, 5'd7);
      alloc(1'b1, 5'd8);
      cdb(4'd5, 32'h55);
      idle(2);
      chk("ooo_blocked_count", 64'(count), 64'(2));
      cdb(4'd4, 32'h44);
      idle(3);

      // Fill, reject, commit on a full edge, wrap.
      cyc(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b1);
      for (int i = 0; i < 15; i++) alloc(1'b1, 5'(i + 3));
      chk("fill_full", 64'(full), 64'(1));
      chk("fill_count", 64'(count), 64'(15));
      alloc(1'b1, 5'd30);
      chk("reject_count", 64'(count), 64'(15));
      cyc(1'b1, 1'b1, 5'd30, 1'b1, 4'd1, 32'h1234);
      cyc(1'b1, 1'b1, 5'd30, 1'b0, 4'd0, 32'd0);
      chk("full_commit_count", 64'(count), 64'(14));
      chk("full_dropped", 64'(full), 64'(0));
      chk("wrap_tag", 64'(alloc_tag), 64'(1));
      alloc(1'b1, 5'd9);
      chk("wrap_refill_count", 64'(count), 64'(15));

      // Flush with a ready head overrides commit, alloc and CDB.
      cyc(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b1);
      for (int i = 0; i < 5; i++) alloc(1'b1, 5'(i + 1));
      cdb(4'd1, 32'hF00D);
      cyc(1'b1, 1'b1, 5'd4, 1'b1, 4'd2, 32'hBAD, 1'b1);
      chk("flush_count", 64'(count), 64'(0));
      chk("flush_no_commit", 64'(commit_valid), 64'(0));
      chk("flush_tag", 64'(alloc_tag), 64'(1));

      // Asynchronous reset right after a commit pulse.
      alloc(1'b1, 5'd6);
      alloc(1'b1, 5'd7);
      cdb(4'd1, 32'hCAFE);
      idle(1);
      chk("pre_rst_pulse", 64'(commit_valid), 64'(1));
      rst = 1'b1;
      #1;
      chk("arst_commit", 64'({commit_valid, commit_we, commit_addr, commit_data, commit_tag}),
          64'(0));
      chk("arst_count", 64'(count), 64'(0));
      chk("arst_tag", 64'(alloc_tag), 64'(1));
      model_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;

      // rdy low freezes a ready head.
      alloc(1'b1, 5'd11);
      cdb(4'd1, 32'h77);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 5'd12, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      chk("frozen_count", 64'(count), 64'(1));
      idle(2);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         ra  = ($urandom_range(0, 1) == 1);
         rdv = ($urandom_range(0, 3) != 0);
         rad = 5'($urandom_range(0, 31));
         rcd = $urandom;
         rr  = ($urandom_range(0, 7) != 0);
         rfl = ($urandom_range(0, 79) == 0);
         pend.delete();
         foreach (rob_q[j]) if (!rob_q[j].done) pend.push_back(int'(rob_q[j].tag));
         rcv = ($urandom_range(0, 2) != 0);
         if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
            rct = 4'(pend[$urandom_range(0, pend.size() - 1)]);
         end else begin
            rct = 4'($urandom_range(0, 15));
            foreach (rob_q[j]) if (rob_q[j].tag == rct && rob_q[j].done) rcv = 1'b0;
         end
         cyc(ra, rdv, rad, rcv, rct, rcd, rfl, rr);
      end
      idle(20);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
